// File: rtl/sfu_pkg.sv
// Shared SFU definitions.
// Holds the pooling window size and the lane/beat/word width helpers used by
// sfu_max_pool and sfu_pool_pack. No ports; import with sfu_pkg::*.
package sfu_pkg;

  // Beats per packed word (2x2 max-pool window).
  localparam int unsigned POOL_WIN = 4;

  // Default datapath geometry shared by the SFU stages.
  localparam int unsigned PSUM_BW        = 16;
  localparam int unsigned COL            = 8;
  localparam int unsigned LANES_PER_BEAT = COL / POOL_WIN;

  typedef logic [PSUM_BW-1:0]                lane_t;
  typedef logic [LANES_PER_BEAT*PSUM_BW-1:0] beat_t;
  typedef logic [COL*PSUM_BW-1:0]            word_t;

  // Index of the next beat slot inside the word being packed.
  typedef logic [1:0] slot_t;

  // Width in bits of one max-pool beat for a given lane width and lane count.
  function automatic int unsigned beat_bits(input int unsigned psum_bw,
                                            input int unsigned col);
    return (col / POOL_WIN) * psum_bw;
  endfunction

endpackage

// File: rtl/sfu_out_reg.sv
// One-entry valid/ready output register with a running write address.
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   clear             drop any held word and reload the address with clear_addr
//   clear_addr        address loaded on clear
//   load, load_data   capture a new word (caller guarantees ~out_valid | out_ready)
//   out_valid/ready   downstream handshake
//   out_data          held word
//   out_addr          address of out_data; advances by one on each transfer
module sfu_out_reg #(
  parameter int unsigned data_bw = 128,
  parameter int unsigned addr_bw = 11
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic [addr_bw-1:0] clear_addr,
  input  logic               load,
  input  logic [data_bw-1:0] load_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [data_bw-1:0] out_data,
  output logic [addr_bw-1:0] out_addr
);

  logic xfer;

  assign xfer = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= clear_addr;
    end else begin
      // The address register always names the next word to be written, so a
      // word loaded in the same cycle as a transfer picks up the bumped value.
      if (xfer) begin
        out_addr <= out_addr + addr_bw'(1);
      end
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= load_data;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/sfu_pool_pack.sv
// Packs four narrow max-pool beats into one full col-lane word and hands each
// word, with a running SRAM write address, to the output writer.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   start_i, base_addr_i       restart: load base address, clear packer/count
//   in_valid_i, pool_in,
//   in_ready_o                 beat input handshake (beat 0 lands in the LSBs)
//   flush_i                    emit a partially filled word, unused slots zero
//   wr_valid_o, wr_ready_i,
//   wr_data_o, wr_addr_o       packed word output handshake
//   word_cnt_o                 words transferred since start_i
//   busy_o                     beats pending in the packer or word pending
module sfu_pool_pack
  import sfu_pkg::*;
#(
  parameter int unsigned psum_bw = 16,
  parameter int unsigned col     = 8,
  parameter int unsigned addr_bw = 11
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start_i,
  input  logic [addr_bw-1:0]                base_addr_i,
  input  logic                              in_valid_i,
  input  logic [beat_bits(psum_bw,col)-1:0] pool_in,
  output logic                              in_ready_o,
  input  logic                              flush_i,
  output logic                              wr_valid_o,
  input  logic                              wr_ready_i,
  output logic [col*psum_bw-1:0]            wr_data_o,
  output logic [addr_bw-1:0]                wr_addr_o,
  output logic [addr_bw-1:0]                word_cnt_o,
  output logic                              busy_o
);

  localparam int unsigned B = beat_bits(psum_bw, col);
  localparam int unsigned W = col * psum_bw;
  localparam slot_t LAST_SLOT = slot_t'(POOL_WIN - 1);

  // Only the first three beats are stored; the fourth goes straight into the
  // output register together with them.
  logic [(POOL_WIN-1)*B-1:0] pack_q;
  slot_t                     slot_q;
  logic [addr_bw-1:0]        word_cnt_q;

  logic   space_ok;
  logic   accept;
  logic   complete;
  logic   flush_emit;
  logic   load;
  logic   xfer;
  slot_t  slot_after;
  logic [W-1:0] merged;

  // Output register can take a word this cycle (empty or draining).
  assign space_ok   = ~wr_valid_o | wr_ready_i;
  assign in_ready_o = ~start_i & ((slot_q != LAST_SLOT) | space_ok);
  assign accept     = in_valid_i & in_ready_o;
  assign complete   = accept & (slot_q == LAST_SLOT);
  assign slot_after = accept ? slot_q + slot_t'(1) : slot_q;

  // A flush looks at the fill level after any same-cycle beat; when that beat
  // already completes the word there is nothing left to pad.
  assign flush_emit = flush_i & ~start_i & ~complete & (slot_after != '0) & space_ok;
  assign load       = complete | flush_emit;
  assign xfer       = wr_valid_o & wr_ready_i;

  // Stored beats plus the beat accepted this cycle; untouched slots read zero
  // because pack_q is cleared whenever a word leaves the packer.
  always_comb begin
    merged = {{B{1'b0}}, pack_q};
    if (accept) begin
      for (int unsigned k = 0; k < POOL_WIN; k++) begin
        if (slot_q == slot_t'(k)) begin
          merged[k*B +: B] = pool_in;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q     <= '0;
      pack_q     <= '0;
      word_cnt_q <= '0;
    end else if (start_i) begin
      slot_q     <= '0;
      pack_q     <= '0;
      word_cnt_q <= '0;
    end else begin
      if (xfer) begin
        word_cnt_q <= word_cnt_q + addr_bw'(1);
      end
      if (load) begin
        slot_q <= '0;
        pack_q <= '0;
      end else if (accept) begin
        slot_q <= slot_after;
        pack_q <= merged[(POOL_WIN-1)*B-1:0];
      end
    end
  end

  sfu_out_reg #(
    .data_bw (W),
    .addr_bw (addr_bw)
  ) u_out_reg (
    .clk        (clk),
    .reset      (reset),
    .clear      (start_i),
    .clear_addr (base_addr_i),
    .load       (load),
    .load_data  (merged),
    .out_valid  (wr_valid_o),
    .out_ready  (wr_ready_i),
    .out_data   (wr_data_o),
    .out_addr   (wr_addr_o)
  );

  assign word_cnt_o = word_cnt_q;
  assign busy_o     = (slot_q != '0) | wr_valid_o;

endmodule

// File: tb/tb_sfu_pool_pack.sv
module tb_sfu_pool_pack;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_i;
  logic [10:0]  base_addr_i;
  logic         in_valid_i;
  logic [31:0]  pool_in;
  logic         in_ready_o;
  logic         flush_i;
  logic         wr_valid_o;
  logic         wr_ready_i;
  logic [127:0] wr_data_o;
  logic [10:0]  wr_addr_o;
  logic [10:0]  word_cnt_o;
  logic         busy_o;

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of beats waiting to become a word, plus the
  // single output slot and the address/count registers.
  logic [31:0]  m_beats[$];
  logic         m_valid;
  logic [127:0] m_data;
  logic [10:0]  m_addr;
  logic [10:0]  m_cnt;
  logic         m_busy;

  // Per-cycle observations taken just before the clock edge.
  logic         exp_ready_l;
  logic         obs_ready_l;
  logic         obs_xfer;
  logic [10:0]  obs_addr;

  sfu_pool_pack #(
    .psum_bw (16),
    .col     (8),
    .addr_bw (11)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .in_valid_i  (in_valid_i),
    .pool_in     (pool_in),
    .in_ready_o  (in_ready_o),
    .flush_i     (flush_i),
    .wr_valid_o  (wr_valid_o),
    .wr_ready_i  (wr_ready_i),
    .wr_data_o   (wr_data_o),
    .wr_addr_o   (wr_addr_o),
    .word_cnt_o  (word_cnt_o),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] pack_beats();
    logic [127:0] w;
    w = '0;
    for (int i = 0; i < m_beats.size(); i++) w[i*32 +: 32] = m_beats[i];
    return w;
  endfunction

  // Drive one cycle of inputs (called at posedge+1), sample, clock, update model.
  task automatic cyc(input logic rst, input logic st, input logic [10:0] base,
                     input logic v, input logic [31:0] d, input logic fl,
                     input logic rdy);
    logic xfer;
    logic space;
    logic emit;
    reset = rst; start_i = st; base_addr_i = base; in_valid_i = v;
    pool_in = d; flush_i = fl; wr_ready_i = rdy;
    #3;
    exp_ready_l = !st && (m_beats.size() != 3 || !m_valid || rdy);
    obs_ready_l = in_ready_o;
    obs_xfer    = wr_valid_o & wr_ready_i;
    obs_addr    = wr_addr_o;
    @(posedge clk);
    #1;
    if (rst) begin
      m_beats.delete(); m_valid = 0; m_data = '0; m_addr = '0; m_cnt = '0;
    end else if (st) begin
      m_beats.delete(); m_valid = 0; m_addr = base; m_cnt = '0;
    end else begin
      xfer  = m_valid && rdy;
      space = !m_valid || rdy;
      if (v && exp_ready_l) m_beats.push_back(d);
      emit = (m_beats.size() == 4) || (fl && space && m_beats.size() > 0);
      if (xfer) begin
        m_addr = m_addr + 11'd1;
        m_cnt  = m_cnt + 11'd1;
        m_valid = 0;
      end
      if (emit) begin
        m_data  = pack_beats();
        m_valid = 1;
        m_beats.delete();
      end
    end
    m_busy = (m_beats.size() != 0) || m_valid;
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 1, 32'hDEAD_BEEF, 1, 1);
    total++;
    if ({wr_valid_o, wr_data_o, wr_addr_o, word_cnt_o, busy_o} !== '0) begin
      bad++;
      $display("FAIL reset_state: got v=%0b d=%h a=%h c=%h b=%0b want all zero",
               wr_valid_o, wr_data_o, wr_addr_o, word_cnt_o, busy_o);
    end
  endtask

  task automatic test_basic();
    logic [31:0] b[4];
    b[0] = 32'h0002_0001; b[1] = 32'h0004_0003;
    b[2] = 32'h0006_0005; b[3] = 32'h0008_0007;
    cyc(0, 1, 11'h010, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 1, b[i], 0, 1);
      total++;
      if (obs_ready_l !== 1'b1) begin
        bad++; $display("FAIL basic_ready: beat %0d got %0b want 1", i, obs_ready_l);
      end
    end
    total++;
    if (wr_valid_o !== 1'b1 || wr_data_o !== 128'h00080007_00060005_00040003_00020001
        || wr_addr_o !== 11'h010) begin
      bad++;
      $display("FAIL basic_word: got v=%0b d=%h a=%h want v=1 d=00080007000600050004000300020001 a=010",
               wr_valid_o, wr_data_o, wr_addr_o);
    end
    cyc(0, 0, 0, 0, 0, 0, 1);
    total++;
    if (wr_valid_o !== 1'b0 || wr_addr_o !== 11'h011 || word_cnt_o !== 11'd1) begin
      bad++;
      $display("FAIL basic_after: got v=%0b a=%h c=%0d want v=0 a=011 c=1",
               wr_valid_o, wr_addr_o, word_cnt_o);
    end
  endtask

  task automatic test_back_pressure();
    logic [10:0] xa[$];
    int n = 0;
    int c = 0;
    int stalls = 0;
    cyc(0, 1, 11'h010, 0, 0, 0, 0);
    while ((n < 8 || m_valid) && c < 60) begin
      cyc(0, 0, 0, n < 8, 32'hA000_0000 + n, 0, c >= 9);
      if (n < 8 && exp_ready_l) n++;
      if (n < 8 && !obs_ready_l) stalls++;
      if (obs_xfer) xa.push_back(obs_addr);
      total++;
      if (obs_ready_l !== exp_ready_l ||
          {wr_valid_o, wr_addr_o, word_cnt_o, busy_o} !== {m_valid, m_addr, m_cnt, m_busy} ||
          (m_valid && wr_data_o !== m_data)) begin
        bad++;
        $display("FAIL bp_cycle%0d: got r=%0b v=%0b a=%h c=%0d d=%h want r=%0b v=%0b a=%h c=%0d d=%h",
                 c, obs_ready_l, wr_valid_o, wr_addr_o, word_cnt_o, wr_data_o,
                 exp_ready_l, m_valid, m_addr, m_cnt, m_data);
      end
      c++;
    end
    total++;
    if (c >= 60) begin bad++; $display("FAIL bp_timeout: got %0d cycles want <60", c); end
    total++;
    if (stalls == 0) begin bad++; $display("FAIL bp_stall: got 0 stalled beats want >0"); end
    total++;
    if (xa.size() != 2 || xa[0] !== 11'h010 || xa[1] !== 11'h011) begin
      bad++; $display("FAIL bp_addrs: got %0d words want 2 at 010,011", xa.size());
    end
  endtask

  task automatic test_flush();
    cyc(0, 1, 11'h010, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 32'h1111_1111, 0, 0);
    cyc(0, 0, 0, 1, 32'h2222_2222, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 0);
    total++;
    if (wr_valid_o !== 1'b1 || wr_data_o !== 128'h00000000_00000000_22222222_11111111) begin
      bad++;
      $display("FAIL flush_word: got v=%0b d=%h want v=1 d=00000000000000002222222211111111",
               wr_valid_o, wr_data_o);
    end
    cyc(0, 0, 0, 0, 0, 0, 1);
    total++;
    if (busy_o !== 1'b0 || wr_valid_o !== 1'b0 || word_cnt_o !== 11'd1) begin
      bad++;
      $display("FAIL flush_after: got b=%0b v=%0b c=%0d want b=0 v=0 c=1",
               busy_o, wr_valid_o, word_cnt_o);
    end
    // Flush with nothing packed must not create a word.
    cyc(0, 0, 0, 0, 0, 1, 1);
    total++;
    if (wr_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL flush_empty: got v=%0b b=%0b want v=0 b=0", wr_valid_o, busy_o);
    end
  endtask

  task automatic test_flush_full();
    cyc(0, 1, 11'h010, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 32'hC0DE_0000 + i, 0, 0);
    cyc(0, 0, 0, 1, 32'hC0DE_0003, 1, 0);
    total++;
    if (wr_valid_o !== 1'b1 || wr_data_o !== 128'hC0DE0003_C0DE0002_C0DE0001_C0DE0000) begin
      bad++; $display("FAIL flushfull_word: got v=%0b d=%h want full word", wr_valid_o, wr_data_o);
    end
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    total++;
    if (wr_valid_o !== 1'b0 || busy_o !== 1'b0 || word_cnt_o !== 11'd1) begin
      bad++;
      $display("FAIL flushfull_extra: got v=%0b b=%0b c=%0d want v=0 b=0 c=1",
               wr_valid_o, busy_o, word_cnt_o);
    end
  endtask

  task automatic test_wrap();
    logic [10:0] xa[$];
    cyc(0, 1, 11'h7FF, 0, 0, 0, 1);
    for (int i = 0; i < 14; i++) begin
      cyc(0, 0, 0, i < 12, $urandom, 0, 1);
      if (obs_xfer) xa.push_back(obs_addr);
    end
    total++;
    if (xa.size() != 3 || xa[0] !== 11'h7FF || xa[1] !== 11'h000 || xa[2] !== 11'h001) begin
      bad++; $display("FAIL wrap_addrs: got %0d words want 3 at 7ff,000,001", xa.size());
    end
    total++;
    if (word_cnt_o !== 11'd3 || wr_addr_o !== 11'h002) begin
      bad++; $display("FAIL wrap_count: got c=%0d a=%h want c=3 a=002", word_cnt_o, wr_addr_o);
    end
  endtask

  task automatic test_reset_mid();
    cyc(0, 1, 11'h010, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 0, 1, 32'h5A00_0000 + i, 0, 0);
    total++;
    if (wr_valid_o !== 1'b1 || busy_o !== 1'b1) begin
      bad++; $display("FAIL rstmid_pending: got v=%0b b=%0b want v=1 b=1", wr_valid_o, busy_o);
    end
    cyc(1, 0, 0, 0, 0, 0, 0);
    total++;
    if ({wr_valid_o, wr_data_o, wr_addr_o, word_cnt_o, busy_o} !== '0) begin
      bad++;
      $display("FAIL rstmid_zero: got v=%0b a=%h c=%0d b=%0b want all zero",
               wr_valid_o, wr_addr_o, word_cnt_o, busy_o);
    end
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 32'h0BEE_0000 + i, 0, 1);
    total++;
    if (wr_valid_o !== 1'b1 || wr_addr_o !== 11'h000 ||
        wr_data_o !== 128'h0BEE0003_0BEE0002_0BEE0001_0BEE0000) begin
      bad++;
      $display("FAIL rstmid_fresh: got v=%0b a=%h d=%h want v=1 a=000 fresh word",
               wr_valid_o, wr_addr_o, wr_data_o);
    end
  endtask

  task automatic test_random();
    cyc(0, 1, 11'h123, 0, 0, 0, 0);
    for (int c = 0; c < 600; c++) begin
      cyc(0, ($urandom_range(0, 79) == 0), 11'($urandom),
          ($urandom_range(0, 3) != 0), $urandom,
          ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0));
      total++;
      if (obs_ready_l !== exp_ready_l ||
          {wr_valid_o, wr_addr_o, word_cnt_o, busy_o} !== {m_valid, m_addr, m_cnt, m_busy} ||
          (m_valid && wr_data_o !== m_data)) begin
        bad++;
        $display("FAIL rand_cycle%0d: got r=%0b v=%0b a=%h c=%0d b=%0b d=%h want r=%0b v=%0b a=%h c=%0d b=%0b d=%h",
                 c, obs_ready_l, wr_valid_o, wr_addr_o, word_cnt_o, busy_o, wr_data_o,
                 exp_ready_l, m_valid, m_addr, m_cnt, m_busy, m_data);
      end
    end
  endtask

  initial begin
    reset = 1; start_i = 0; base_addr_i = '0; in_valid_i = 0;
    pool_in = '0; flush_i = 0; wr_ready_i = 0;
    m_valid = 0; m_data = '0; m_addr = '0; m_cnt = '0; m_busy = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_back_pressure();
    test_flush();
    test_flush_full();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
